// File: rtl/vga_sync_gen.sv
// Raster timing generator for a 640x480@60 display (one pixel per clk).
// The counters pix_x/pix_y walk the full raster, including blanking.
// Every output is a flop: the decodes are computed from the next counter
// values and registered, so they stay aligned with the counters and the
// sync lines are free of glitches.
module vga_sync_gen #(
  parameter int H_ACTIVE    = 640,
  parameter int H_FP        = 16,
  parameter int H_SYNC      = 96,
  parameter int H_BP        = 48,
  parameter int V_ACTIVE    = 480,
  parameter int V_FP        = 10,
  parameter int V_SYNC      = 2,
  parameter int V_BP        = 33,
  parameter int SYNC_ACTIVE = 0
) (
  input  logic       clk,
  input  logic       reset,
  output logic [9:0] pix_x,
  output logic [9:0] pix_y,
  output logic       display_on,
  output logic       hsync,
  output logic       vsync,
  output logic       line_start,
  output logic       frame_start,
  output logic [7:0] frame_count
);

  // Both totals must fit the 10-bit counters (<= 1024).
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  // 11-bit boundaries so a total of exactly 1024 still compares correctly.
  localparam logic [10:0] H_LAST       = 11'(H_TOTAL - 1);
  localparam logic [10:0] V_LAST       = 11'(V_TOTAL - 1);
  localparam logic [10:0] H_ACT_END    = 11'(H_ACTIVE);
  localparam logic [10:0] V_ACT_END    = 11'(V_ACTIVE);
  localparam logic [10:0] H_SYNC_START = 11'(H_ACTIVE + H_FP);
  localparam logic [10:0] H_SYNC_END   = 11'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [10:0] V_SYNC_START = 11'(V_ACTIVE + V_FP);
  localparam logic [10:0] V_SYNC_END   = 11'(V_ACTIVE + V_FP + V_SYNC);

  localparam logic SYNC_ON  = 1'(SYNC_ACTIVE);
  localparam logic SYNC_OFF = ~SYNC_ON;

  logic       x_wrap;
  logic       y_wrap;
  logic [9:0] x_next;
  logic [9:0] y_next;

  // Half-open range test [lo, hi) on a counter value.
  function automatic logic in_range(input logic [9:0] v,
                                    input logic [10:0] lo,
                                    input logic [10:0] hi);
    return ({1'b0, v} >= lo) && ({1'b0, v} < hi);
  endfunction

  // Next raster position: x wraps at end of line, y steps only on x wrap.
  always_comb begin
    x_wrap = ({1'b0, pix_x} == H_LAST);
    y_wrap = ({1'b0, pix_y} == V_LAST);
    x_next = x_wrap ? 10'd0 : pix_x + 10'd1;
    y_next = pix_y;
    if (x_wrap) begin
      y_next = y_wrap ? 10'd0 : pix_y + 10'd1;
    end
  end

  // Counters plus registered decodes of the position being entered.
  always_ff @(posedge clk) begin
    if (reset) begin
      pix_x       <= 10'd0;
      pix_y       <= 10'd0;
      frame_count <= 8'd0;
      display_on  <= 1'b1;
      hsync       <= SYNC_OFF;
      vsync       <= SYNC_OFF;
      line_start  <= 1'b1;
      frame_start <= 1'b1;
    end else begin
      pix_x <= x_next;
      pix_y <= y_next;
      if (x_wrap && y_wrap) begin
        frame_count <= frame_count + 8'd1;
      end
      display_on  <= in_range(x_next, 11'd0, H_ACT_END) &&
                     in_range(y_next, 11'd0, V_ACT_END);
      hsync       <= in_range(x_next, H_SYNC_START, H_SYNC_END) ? SYNC_ON : SYNC_OFF;
      vsync       <= in_range(y_next, V_SYNC_START, V_SYNC_END) ? SYNC_ON : SYNC_OFF;
      line_start  <= (x_next == 10'd0);
      frame_start <= (x_next == 10'd0) && (y_next == 10'd0);
    end
  end

endmodule
